core_ctrl: RTL

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/core_ctrl.sv
`timescale 1ns/1ps
// core_ctrl: opcode sequencer for the image-processing core. Accepts one
// opcode at a time, runs pixel loads, steps the 2x2 display window origin,
// rescales the active channel depth and launches datapath operations whose
// completion is tracked by counting output beats.
module core_ctrl #(
    parameter int INST_BW    = 4,
    parameter int IMG_W      = 8,
    parameter int IMG_MAX_CH = 32,
    parameter int ADDR_BW    = 11
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_op_valid,
    input  logic [INST_BW-1:0]         i_op_mode,
    output logic                       o_op_ready,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic                       i_out_valid,
    output logic                       o_load_we,
    output logic [ADDR_BW-1:0]         o_load_addr,
    output logic [$clog2(IMG_W)-1:0]   o_org_x,
    output logic [$clog2(IMG_W)-1:0]   o_org_y,
    output logic [1:0]                 o_depth,
    output logic                       o_run_start,
    output logic [INST_BW-1:0]         o_run_mode
);

    localparam int OW     = $clog2(IMG_W);
    localparam int CNT_BW = 8;

    // Last load address: one beat per pixel per channel at full depth.
    localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(IMG_W * IMG_W * IMG_MAX_CH - 1);
    // The 2x2 window must stay fully inside the image.
    localparam logic [OW-1:0]      ORG_MAX   = OW'(IMG_W - 2);

    localparam logic [INST_BW-1:0] OP_LOAD = INST_BW'(0);
    localparam logic [INST_BW-1:0] OP_SHFR = INST_BW'(1);
    localparam logic [INST_BW-1:0] OP_SHFL = INST_BW'(2);
    localparam logic [INST_BW-1:0] OP_SHFU = INST_BW'(3);
    localparam logic [INST_BW-1:0] OP_SHFD = INST_BW'(4);
    localparam logic [INST_BW-1:0] OP_SCAD = INST_BW'(5);
    localparam logic [INST_BW-1:0] OP_SCAU = INST_BW'(6);
    localparam logic [INST_BW-1:0] OP_DISP = INST_BW'(7);
    localparam logic [INST_BW-1:0] OP_CONV = INST_BW'(8);
    localparam logic [INST_BW-1:0] OP_MEDF = INST_BW'(9);
    localparam logic [INST_BW-1:0] OP_GRAD = INST_BW'(10);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_WAIT_OP,
        S_LOAD,
        S_EXEC
    } state_e;

    typedef enum logic [1:0] {
        DEPTH_8  = 2'b00,
        DEPTH_16 = 2'b01,
        DEPTH_32 = 2'b10
    } depth_e;

    state_e               state_q,     state_d;
    logic                 op_ready_q,  op_ready_d;
    logic                 in_ready_q,  in_ready_d;
    logic [ADDR_BW-1:0]   load_addr_q, load_addr_d;
    logic [OW-1:0]        org_x_q,     org_x_d;
    logic [OW-1:0]        org_y_q,     org_y_d;
    depth_e               depth_q,     depth_d;
    logic                 run_start_q, run_start_d;
    logic [INST_BW-1:0]   run_mode_q,  run_mode_d;
    logic [CNT_BW-1:0]    beat_cnt_q,  beat_cnt_d;
    logic [CNT_BW-1:0]    beat_last;
    logic                 load_we;

    // A beat is written only when the controller is actually accepting pixels.
    assign load_we = i_in_valid & in_ready_q;

    // Index of the final output beat for the operation currently executing.
    always_comb begin
        beat_last = '0;
        case (run_mode_q)
            OP_DISP: begin
                case (depth_q)
                    DEPTH_8:  beat_last = CNT_BW'(31);
                    DEPTH_16: beat_last = CNT_BW'(63);
                    default:  beat_last = CNT_BW'(127);
                endcase
            end
            OP_CONV: beat_last = CNT_BW'(3);
            OP_MEDF: beat_last = CNT_BW'(15);
            OP_GRAD: beat_last = CNT_BW'(15);
            default: beat_last = '0;
        endcase
    end

    // Next-state and next-output logic for the opcode sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        load_addr_d = load_addr_q;
        org_x_d     = org_x_q;
        org_y_d     = org_y_q;
        depth_d     = depth_q;
        run_start_d = 1'b0;
        run_mode_d  = run_mode_q;
        beat_cnt_d  = beat_cnt_q;

        case (state_q)
            S_IDLE:  state_d = S_READY;
            S_READY: state_d = S_WAIT_OP;
            S_WAIT_OP: begin
                if (i_op_valid) begin
                    // Window and depth opcodes, and reserved ones, finish here.
                    state_d = S_READY;
                    case (i_op_mode)
                        OP_LOAD: begin
                            state_d     = S_LOAD;
                            in_ready_d  = 1'b1;
                            load_addr_d = '0;
                            org_x_d     = '0;
                            org_y_d     = '0;
                            depth_d     = DEPTH_32;
                        end
                        OP_SHFR: if (org_x_q < ORG_MAX) org_x_d = org_x_q + 1'b1;
                        OP_SHFL: if (org_x_q != '0)     org_x_d = org_x_q - 1'b1;
                        OP_SHFD: if (org_y_q < ORG_MAX) org_y_d = org_y_q + 1'b1;
                        OP_SHFU: if (org_y_q != '0)     org_y_d = org_y_q - 1'b1;
                        OP_SCAD: begin
                            case (depth_q)
                                DEPTH_32: depth_d = DEPTH_16;
                                DEPTH_16: depth_d = DEPTH_8;
                                default:  depth_d = DEPTH_8;
                            endcase
                        end
                        OP_SCAU: begin
                            case (depth_q)
                                DEPTH_8:  depth_d = DEPTH_16;
                                DEPTH_16: depth_d = DEPTH_32;
                                default:  depth_d = DEPTH_32;
                            endcase
                        end
                        OP_DISP, OP_CONV, OP_MEDF, OP_GRAD: begin
                            state_d     = S_EXEC;
                            run_start_d = 1'b1;
                            run_mode_d  = i_op_mode;
                            beat_cnt_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (load_we) begin
                    // The counter parks at the last address instead of wrapping.
                    if (load_addr_q == LAST_ADDR) begin
                        in_ready_d = 1'b0;
                        state_d    = S_READY;
                    end else begin
                        load_addr_d = load_addr_q + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (i_out_valid) begin
                    if (beat_cnt_q == beat_last) begin
                        beat_cnt_d = '0;
                        state_d    = S_READY;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered ready pulse coincides with the single READY cycle.
        op_ready_d = (state_d == S_READY);
    end

    // State and output registers; reset aborts any load or execution.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            op_ready_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            load_addr_q <= '0;
            org_x_q     <= '0;
            org_y_q     <= '0;
            depth_q     <= DEPTH_32;
            run_start_q <= 1'b0;
            run_mode_q  <= '0;
            beat_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            op_ready_q  <= op_ready_d;
            in_ready_q  <= in_ready_d;
            load_addr_q <= load_addr_d;
            org_x_q     <= org_x_d;
            org_y_q     <= org_y_d;
            depth_q     <= depth_d;
            run_start_q <= run_start_d;
            run_mode_q  <= run_mode_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign o_op_ready  = op_ready_q;
    assign o_in_ready  = in_ready_q;
    assign o_load_we   = load_we;
    assign o_load_addr = load_addr_q;
    assign o_org_x     = org_x_q;
    assign o_org_y     = org_y_q;
    assign o_depth     = depth_q;
    assign o_run_start = run_start_q;
    assign o_run_mode  = run_mode_q;

endmodule
